// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix Memory block and its byte-stream loader.
package matrix_pkg;

   localparam int         DEF_ADDR_SIZE = 10;
   localparam int         DEF_WORD_SIZE = 16;
   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR_L = 3'd1,
      ST_ADDR_H = 3'd2,
      ST_LEN_L  = 3'd3,
      ST_LEN_H  = 3'd4,
      ST_DATA_L = 3'd5,
      ST_DATA_H = 3'd6,
      ST_DONE   = 3'd7
   } loader_state_t;

endpackage

// File: rtl/mem_loader.sv
// Parses framed write commands from the MCU byte stream and issues one
// sequential little-endian word write per data word into Memory.
module mem_loader
   import matrix_pkg::*;
#(
   parameter int         ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int         WORD_SIZE = DEF_WORD_SIZE,
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [7:0]           in_data,
   input  logic                 abort,
   output logic [ADDR_SIZE-1:0] w_addr,
   output logic                 w_en,
   output logic [WORD_SIZE-1:0] w_data,
   output logic                 busy,
   output logic                 done,
   output logic                 sync_err
);

   loader_state_t        state_r;
   loader_state_t        state_next_s;
   logic [ADDR_SIZE-1:0] addr_r;
   logic [15:0]          remain_r;
   logic [7:0]           low_r;
   logic                 accept_s;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; abort and DONE advance without a byte
   always_comb begin
      state_next_s = state_r;
      if (abort) begin
         state_next_s = ST_IDLE;
      end else if (state_r == ST_DONE) begin
         state_next_s = ST_IDLE;
      end else if (accept_s) begin
         case (state_r)
            ST_IDLE:   state_next_s = (in_data == SYNC_BYTE) ? ST_ADDR_L : ST_IDLE;
            ST_ADDR_L: state_next_s = ST_ADDR_H;
            ST_ADDR_H: state_next_s = ST_LEN_L;
            ST_LEN_L:  state_next_s = ST_LEN_H;
            ST_LEN_H:  state_next_s = ({in_data, low_r} == 16'd0) ? ST_DONE : ST_DATA_L;
            ST_DATA_L: state_next_s = ST_DATA_H;
            ST_DATA_H: state_next_s = (remain_r == 16'd1) ? ST_DONE : ST_DATA_L;
            default:   state_next_s = ST_IDLE;
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Handshake and status outputs decoded from the state register
   always_comb begin
      in_ready = !abort && (state_r != ST_DONE);
      accept_s = in_valid && in_ready;
      busy     = (state_r != ST_IDLE);
      done     = (state_r == ST_DONE);
   end

   // Field capture, word assembly and registered write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r   <= '0;
         remain_r <= 16'd0;
         low_r    <= 8'd0;
         w_addr   <= '0;
         w_data   <= '0;
         w_en     <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         w_en     <= 1'b0;
         sync_err <= 1'b0;
         if (abort) begin
            low_r <= 8'd0;
         end else if (accept_s) begin
            case (state_r)
               ST_IDLE:   sync_err <= (in_data != SYNC_BYTE);
               ST_ADDR_L: low_r    <= in_data;
               ST_ADDR_H: addr_r   <= ADDR_SIZE'({in_data, low_r});
               ST_LEN_L:  low_r    <= in_data;
               ST_LEN_H:  remain_r <= {in_data, low_r};
               ST_DATA_L: low_r    <= in_data;
               ST_DATA_H: begin
                  w_addr   <= addr_r;
                  w_data   <= WORD_SIZE'({in_data, low_r});
                  w_en     <= 1'b1;
                  addr_r   <= addr_r + ADDR_SIZE'(1);
                  remain_r <= remain_r - 16'd1;
               end
               default:   low_r <= low_r;
            endcase
         end else begin
            low_r <= low_r;
         end
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: frame parsing, wrap, zero length, bad sync,
// abort and asynchronous reset.
module tb_mem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic        abort = 1'b0;
   logic [9:0]  w_addr;
   logic        w_en;
   logic [15:0] w_data;
   logic        busy;
   logic        done;
   logic        sync_err;

   int tests_run = 0;
   int tests_failed = 0;
   bit gap_en = 1'b0;

   int          wr_n = 0;
   int          done_n = 0;
   int          serr_n = 0;
   int          wen_back2back = 0;
   logic        wen_prev = 1'b0;
   logic [9:0]  wr_addr_log [0:63];
   logic [15:0] wr_data_log [0:63];

   mem_loader dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .abort(abort), .w_addr(w_addr), .w_en(w_en),
      .w_data(w_data), .busy(busy), .done(done), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   // Record write-port activity and status pulses away from the active edge
   always @(negedge clk) begin
      wen_prev <= w_en;
      if (w_en) begin
         wr_addr_log[wr_n] <= w_addr;
         wr_data_log[wr_n] <= w_data;
         wr_n <= wr_n + 1;
         if (wen_prev) wen_back2back <= wen_back2back + 1;
      end
      if (done)     done_n <= done_n + 1;
      if (sync_err) serr_n <= serr_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      if (gap_en) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] bytes [], input int count);
      for (int i = 0; i < count; i++) send_byte(bytes[i]);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      int wr0, dn0, se0;
      logic [7:0] fr [];

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_w_addr", w_addr, 10'h000);
      check("rst_w_en", w_en, 1'b0);
      check("rst_w_data", w_data, 16'h0000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sync_err", sync_err, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      rst = 1'b0;

      // Basic three-word frame
      wr0 = wr_n; dn0 = done_n;
      fr = '{8'hA5, 8'h10, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_bytes(fr, 11);
      settle();
      check("basic_wr_count", wr_n - wr0, 3);
      check("basic_a0", wr_addr_log[wr0],     10'h010);
      check("basic_d0", wr_data_log[wr0],     16'h2211);
      check("basic_a1", wr_addr_log[wr0 + 1], 10'h011);
      check("basic_d1", wr_data_log[wr0 + 1], 16'h4433);
      check("basic_a2", wr_addr_log[wr0 + 2], 10'h012);
      check("basic_d2", wr_data_log[wr0 + 2], 16'h6655);
      check("basic_done", done_n - dn0, 1);
      check("basic_busy", busy, 1'b0);
      check("basic_hold_addr", w_addr, 10'h012);
      check("basic_hold_data", w_data, 16'h6655);

      // Address wrap at the top of memory
      wr0 = wr_n;
      fr = '{8'hA5, 8'hFF, 8'h03, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00};
      send_bytes(fr, 9);
      settle();
      check("wrap_wr_count", wr_n - wr0, 2);
      check("wrap_a0", wr_addr_log[wr0],     10'h3FF);
      check("wrap_d0", wr_data_log[wr0],     16'h0001);
      check("wrap_a1", wr_addr_log[wr0 + 1], 10'h000);
      check("wrap_d1", wr_data_log[wr0 + 1], 16'h0002);

      // Zero-length frame: DONE right after LEN_H
      wr0 = wr_n; dn0 = done_n;
      fr = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      send_bytes(fr, 5);
      @(negedge clk);
      #1;
      check("zero_done", done, 1'b1);
      check("zero_ready", in_ready, 1'b0);
      @(negedge clk);
      #1;
      check("zero_done_gone", done, 1'b0);
      check("zero_busy", busy, 1'b0);
      settle();
      check("zero_no_write", wr_n - wr0, 0);
      check("zero_done_count", done_n - dn0, 1);

      // Bad sync byte, then a good frame
      wr0 = wr_n; se0 = serr_n;
      send_byte(8'h3C);
      @(negedge clk);
      #1;
      check("bad_sync_pulse", sync_err, 1'b1);
      check("bad_sync_busy", busy, 1'b0);
      fr = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
      send_bytes(fr, 7);
      settle();
      check("bad_sync_count", serr_n - se0, 1);
      check("recover_wr_count", wr_n - wr0, 1);
      check("recover_a0", wr_addr_log[wr0], 10'h020);
      check("recover_d0", wr_data_log[wr0], 16'hBBAA);

      // Abort after the low byte of word 2 of a 4-word frame
      wr0 = wr_n; dn0 = done_n; se0 = serr_n;
      fr = '{8'hA5, 8'h40, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03};
      send_bytes(fr, 8);
      @(negedge clk);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h05;
      #1;
      check("abort_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      abort    = 1'b0;
      in_valid = 1'b0;
      settle();
      check("abort_busy", busy, 1'b0);
      check("abort_wr_count", wr_n - wr0, 1);
      check("abort_a0", wr_addr_log[wr0], 10'h040);
      check("abort_d0", wr_data_log[wr0], 16'h0201);
      check("abort_no_done", done_n - dn0, 0);
      fr = '{8'hA5, 8'h50, 8'h00, 8'h01, 8'h00, 8'h0D, 8'h0C};
      send_bytes(fr, 7);
      settle();
      check("abort_no_sync_err", serr_n - se0, 0);
      check("post_abort_wr_count", wr_n - wr0, 2);
      check("post_abort_a", wr_addr_log[wr0 + 1], 10'h050);
      check("post_abort_d", wr_data_log[wr0 + 1], 16'h0C0D);

      // Asynchronous reset while the DATA_H byte is offered
      wr0 = wr_n;
      fr = '{8'hA5, 8'h60, 8'h00, 8'h02, 8'h00, 8'h11};
      send_bytes(fr, 6);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h22;
      #2;
      rst = 1'b1;
      #1;
      check("arst_w_addr", w_addr, 10'h000);
      check("arst_w_data", w_data, 16'h0000);
      check("arst_busy", busy, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      settle();
      check("arst_no_write", wr_n - wr0, 0);

      // Frame after reset with random stalls
      gap_en = 1'b1;
      wr0 = wr_n; dn0 = done_n;
      fr = '{8'hA5, 8'h70, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_bytes(fr, 9);
      settle();
      check("gap_wr_count", wr_n - wr0, 2);
      check("gap_a0", wr_addr_log[wr0],     10'h070);
      check("gap_d0", wr_data_log[wr0],     16'h0201);
      check("gap_a1", wr_addr_log[wr0 + 1], 10'h071);
      check("gap_d1", wr_data_log[wr0 + 1], 16'h0403);
      check("gap_done", done_n - dn0, 1);
      check("wen_single_cycle", wen_back2back, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream stage of the matrix Memory block.
- Accepts a byte stream from the MCU link (valid/ready), parses a framed write command and assembles little-endian words.
- Drives Memory's write port (w_addr/w_en/w_data) with one sequential word write per assembled word.
- Reports per-frame completion and framing errors to the control logic.

Parameters:
- ADDR_SIZE, 10, width of the Memory write address; addresses wrap modulo 2^ADDR_SIZE.
- WORD_SIZE, 16, Memory word width; fixed at 2 bytes per word (other values are unsupported).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  byte-stream valid.
- in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready.
- in_data  input  8  stream byte.
- abort  input  1  synchronous abort; returns the block to IDLE.
- w_addr  output  ADDR_SIZE  Memory write address.
- w_en  output  1  Memory write enable, one-cycle pulse per word.
- w_data  output  WORD_SIZE  Memory write data.
- busy  output  1  high while a frame is in progress (state != IDLE).
- done  output  1  one-cycle pulse at frame end.
- sync_err  output  1  one-cycle pulse when a non-SYNC byte arrives in IDLE.

Behaviour:
- Reset (async assert, any state) forces all of the following; a frame in flight is discarded and no partial word is written:
  - state = IDLE
  - w_addr = 0, w_en = 0, w_data = 0
  - busy = 0, done = 0, sync_err = 0
  - internal addr counter, length counter and low-byte register = 0
- Frame format, one byte per transfer:
  - SYNC_BYTE
  - ADDR_L, ADDR_H: base address, little-endian; only bits [ADDR_SIZE-1:0] are kept.
  - LEN_L, LEN_H: word count N, 16-bit unsigned.
  - 2*N data bytes, each word sent low byte first.
- States: IDLE, ADDR_L, ADDR_H, LEN_L, LEN_H, DATA_L, DATA_H, DONE. Transitions occur only on an accepted byte, except DONE and abort.
  - IDLE: byte == SYNC_BYTE -> ADDR_L. Any other byte is dropped, sync_err pulses next cycle, state stays IDLE.
  - ADDR_L -> ADDR_H -> LEN_L -> LEN_H: capture fields.
  - LEN_H: if N == 0 -> DONE; else -> DATA_L.
  - DATA_L: latch low byte -> DATA_H.
  - DATA_H: register a write with w_addr = addr, w_data = {in_data, low}, and w_en = 1 in the next cycle. Then:
    - addr <= addr + 1, wrapping to 0 after 2^ADDR_SIZE - 1.
    - remaining <= remaining - 1.
    - remaining reaching 0 -> DONE; else -> DATA_L.
  - DONE: lasts exactly one cycle. done = 1 and in_ready = 0, then -> IDLE.
- in_ready = 1 in every state except DONE, and is forced 0 while abort = 1 (combinational from abort).
- Write latency: w_en rises 1 cycle after the DATA_H byte is accepted. At full rate, w_en is high every other cycle at most.
- w_addr and w_data hold their last values when w_en = 0.
- N larger than 2^ADDR_SIZE is legal: writes continue past the wrap point and overwrite earlier words.
- Abort (synchronous):
  - In any state: next state = IDLE; an in-flight low byte is discarded; no done pulse.
  - A write already registered (w_en high in the abort cycle) still completes.
  - Abort in the same cycle as a valid byte: abort wins, the byte is not accepted (in_ready = 0).
- Stream stalls (in_valid = 0) in any state hold all state; there is no timeout.

Decomposition:
- Package matrix_pkg holds:
  - ADDR_SIZE and WORD_SIZE defaults, shared with Memory.
  - SYNC_BYTE constant.
  - loader_state_t enum with the 8 states above.
- The block is a single module with no sub-modules; the FSM, counters and byte assembler are tightly coupled.

Test Plan:
- Basic frame: A5 10 00 03 00 then 11 22 33 44 55 66 ->
  - writes (0x010, 0x2211), (0x011, 0x4433), (0x012, 0x6655), each w_en a single-cycle pulse;
  - done pulses once; busy returns to 0.
- Wrap-around: base 0x3FF, N = 2, data 01 00 02 00 -> writes (0x3FF, 0x0001) then (0x000, 0x0002).
- Zero length: A5 00 00 00 00 -> no w_en; done pulses 1 cycle after the LEN_H byte; in_ready = 0 in that DONE cycle.
- Bad sync, then recovery: bytes 3C, A5 ... valid frame -> sync_err pulses once for 0x3C, no write occurs, and the following frame completes normally.
- Mid-frame abort: abort asserted after the DATA_L byte of word 2 of a 4-word frame ->
  - exactly 1 write occurs; no done;
  - next frame A5 ... parses correctly from IDLE.
- Async reset mid-frame:
  - rst during DATA_H -> outputs 0 immediately, no write;
  - with random in_valid gaps, a frame sent after reset lands at the correct addresses.
